uart_alu_ctrl: RTL and testbench

//   Sequences the UART receive/transmit datapath around the ALU.
//   - Collects three bytes from uart_rx: operand A, operand B, then opcode.
//   - Drives them to the combinational ALU and captures the result.
//   - Hands the result to uart_tx and waits for transmission to complete.

---
 rtl/uart_alu_ctrl.sv | 155 +++++++++++++++
 tb/tb_uart_alu_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: frames three received bytes (operand A, operand B, opcode)
// for a combinational ALU, captures the result and hands it to uart_tx.
// A partial frame is dropped if the next byte does not arrive within
// TIMEOUT_CYC cycles. Bytes that arrive while a frame is being executed or
// transmitted are dropped and flagged with a sticky overrun bit.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for operand A; only state with busy low
// GET_B   | A held, waiting for operand B (inter-byte timer running)
// GET_OP  | A/B held, waiting for opcode (inter-byte timer running)
// EXEC    | operands and opcode stable, ALU settling; result captured
// SEND    | tx_start high for this single cycle
// WAIT_TX | waiting for uart_tx to report the byte as sent

module uart_alu_ctrl #(
    parameter int NB_DATA     = 8,
    parameter int NB_OP       = 6,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_done_tick,
    input  logic [NB_DATA-1:0] rx_data,
    input  logic [NB_DATA-1:0] alu_result,
    input  logic               tx_done_tick,
    output logic [NB_DATA-1:0] alu_a,
    output logic [NB_DATA-1:0] alu_b,
    output logic [NB_OP-1:0]   alu_op,
    output logic [NB_DATA-1:0] tx_data,
    output logic               tx_start,
    output logic               busy,
    output logic               overrun,
    output logic               timeout_tick
);

    // The timer is a down-counter loaded with TIMEOUT_CYC-1 whenever a byte
    // is accepted; reaching zero without a byte means the frame has expired.
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TO_LOAD =
        (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;
    localparam bit TO_ENABLE = (TIMEOUT_CYC > 0);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_B   = 3'd1,
        GET_OP  = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] tmr;
    logic             tmr_expired;
    logic             byte_dropped;

    // Only the low NB_OP bits of the opcode byte carry meaning.
    logic unused_rx_hi;
    assign unused_rx_hi = ^rx_data;

    // Expiry and overrun qualifiers derived from the current state.
    assign tmr_expired  = TO_ENABLE && (tmr == '0);
    assign byte_dropped = rx_done_tick &&
                          ((state == EXEC) || (state == SEND) || (state == WAIT_TX));

    // Frame sequencer: state, timer and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            tmr          <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= '0;
            tx_data      <= '0;
            tx_start     <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            timeout_tick <= 1'b0;
        end else begin
            tx_start     <= 1'b0;
            timeout_tick <= 1'b0;

            case (state)
                IDLE: begin
                    if (rx_done_tick) begin
                        alu_a   <= rx_data;
                        overrun <= 1'b0;
                        tmr     <= TO_LOAD;
                        busy    <= 1'b1;
                        state   <= GET_B;
                    end
                end

                GET_B: begin
                    // A byte arriving on the expiry cycle still wins.
                    if (rx_done_tick) begin
                        alu_b <= rx_data;
                        tmr   <= TO_LOAD;
                        state <= GET_OP;
                    end else if (tmr_expired) begin
                        timeout_tick <= 1'b1;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end else if (TO_ENABLE) begin
                        tmr <= tmr - CNT_W'(1);
                    end
                end

                GET_OP: begin
                    if (rx_done_tick) begin
                        alu_op <= rx_data[NB_OP-1:0];
                        tmr    <= TO_LOAD;
                        state  <= EXEC;
                    end else if (tmr_expired) begin
                        timeout_tick <= 1'b1;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end else if (TO_ENABLE) begin
                        tmr <= tmr - CNT_W'(1);
                    end
                end

                EXEC: begin
                    // Opcode registered last cycle; the ALU has had a full
                    // cycle to settle before its result is captured.
                    tx_data  <= alu_result;
                    tx_start <= 1'b1;
                    state    <= SEND;
                end

                SEND: begin
                    state <= WAIT_TX;
                end

                WAIT_TX: begin
                    if (tx_done_tick) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase

            if (byte_dropped) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed bench for uart_alu_ctrl. dut0 uses the default (long) timeout,
// dut1 uses TIMEOUT_CYC=50 to exercise frame expiry.
`timescale 1ns/1ps

module tb_uart_alu_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_tick0 = 1'b0;
    logic       rx_tick1 = 1'b0;
    logic       tx_done = 1'b0;

    logic [7:0] alu_a0, alu_b0, tx_data0, alu_result0;
    logic [5:0] alu_op0;
    logic       tx_start0, busy0, overrun0, timeout_tick0;

    logic [7:0] alu_a1, alu_b1, tx_data1, alu_result1;
    logic [5:0] alu_op1;
    logic       tx_start1, busy1, overrun1, timeout_tick1;

    int n_cmp = 0;
    int n_bad = 0;
    int starts0 = 0;

    always #5 clk = ~clk;

    // Reference ALU: ADD=0x20, SUB=0x22, AND=0x24, anything else gives 0.
    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result0 = alu_model(alu_a0, alu_b0, alu_op0);
    assign alu_result1 = alu_model(alu_a1, alu_b1, alu_op1);

    always @(posedge clk) if (tx_start0) starts0++;

    uart_alu_ctrl dut0 (
        .clk(clk), .reset(reset), .rx_done_tick(rx_tick0), .rx_data(rx_data),
        .alu_result(alu_result0), .tx_done_tick(tx_done),
        .alu_a(alu_a0), .alu_b(alu_b0), .alu_op(alu_op0), .tx_data(tx_data0),
        .tx_start(tx_start0), .busy(busy0), .overrun(overrun0),
        .timeout_tick(timeout_tick0)
    );

    uart_alu_ctrl #(.TIMEOUT_CYC(50)) dut1 (
        .clk(clk), .reset(reset), .rx_done_tick(rx_tick1), .rx_data(rx_data),
        .alu_result(alu_result1), .tx_done_tick(tx_done),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1), .tx_data(tx_data1),
        .tx_start(tx_start1), .busy(busy1), .overrun(overrun1),
        .timeout_tick(timeout_tick1)
    );

    // Each stimulus task leaves time 1ns after the edge that consumed it.
    task automatic send0(input logic [7:0] d);
        @(posedge clk); #1;
        rx_data = d; rx_tick0 = 1'b1;
        @(posedge clk); #1;
        rx_tick0 = 1'b0;
    endtask

    task automatic send1(input logic [7:0] d);
        @(posedge clk); #1;
        rx_data = d; rx_tick1 = 1'b1;
        @(posedge clk); #1;
        rx_tick1 = 1'b0;
    endtask

    task automatic pulse_tx_done();
        @(posedge clk); #1;
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
    endtask

    task automatic wait_start0(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (tx_start0) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_start1(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (tx_start1) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({alu_a0, alu_b0, alu_op0, tx_data0, tx_start0, busy0, overrun0, timeout_tick0} !== 38'h0) begin
            n_bad++;
            $display("FAIL reset_dut0: got a=%h b=%h op=%h tx=%h st=%b busy=%b ovr=%b to=%b want all 0",
                     alu_a0, alu_b0, alu_op0, tx_data0, tx_start0, busy0, overrun0, timeout_tick0);
        end
        n_cmp++;
        if ({alu_a1, alu_b1, alu_op1, tx_data1, tx_start1, busy1, overrun1, timeout_tick1} !== 38'h0) begin
            n_bad++;
            $display("FAIL reset_dut1: got a=%h b=%h op=%h busy=%b want all 0", alu_a1, alu_b1, alu_op1, busy1);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_frame();
        send0(8'h05);
        n_cmp++;
        if (busy0 !== 1'b1) begin n_bad++; $display("FAIL single_busy_after_a: got %b want 1", busy0); end
        repeat (159) @(posedge clk);
        #1;
        send0(8'h03);
        repeat (159) @(posedge clk);
        #1;
        send0(8'h20);
        // cycle N+1
        n_cmp++;
        if ({alu_a0, alu_b0, alu_op0} !== {8'h05, 8'h03, 6'h20}) begin
            n_bad++;
            $display("FAIL single_operands: got a=%h b=%h op=%h want 05 03 20", alu_a0, alu_b0, alu_op0);
        end
        n_cmp++;
        if (tx_start0 !== 1'b0) begin n_bad++; $display("FAIL single_start_early: got %b want 0 at N+1", tx_start0); end
        @(posedge clk); #1;
        // cycle N+2
        n_cmp++;
        if (tx_start0 !== 1'b1) begin n_bad++; $display("FAIL single_start_n2: got %b want 1", tx_start0); end
        n_cmp++;
        if (tx_data0 !== 8'h08) begin n_bad++; $display("FAIL single_tx_data: got %h want 08", tx_data0); end
        @(posedge clk); #1;
        n_cmp++;
        if ({tx_start0, busy0} !== 2'b01) begin
            n_bad++; $display("FAIL single_wait_tx: got start=%b busy=%b want 0 1", tx_start0, busy0);
        end
        pulse_tx_done();
        n_cmp++;
        if (busy0 !== 1'b0) begin n_bad++; $display("FAIL single_busy_end: got %b want 0", busy0); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int s;
        s = starts0;
        send0(8'hFF); send0(8'h01); send0(8'h20);
        wait_start0(ok);
        n_cmp++;
        if (!ok || tx_data0 !== 8'h00) begin
            n_bad++; $display("FAIL b2b_frame1: got seen=%0d tx=%h want seen=1 tx=00", ok, tx_data0);
        end
        pulse_tx_done();
        n_cmp++;
        if (starts0 - s !== 1) begin n_bad++; $display("FAIL b2b_starts1: got %0d want 1", starts0 - s); end
        send0(8'h0A); send0(8'h0A); send0(8'h22);
        wait_start0(ok);
        n_cmp++;
        if (!ok || tx_data0 !== 8'h00 || alu_op0 !== 6'h22) begin
            n_bad++; $display("FAIL b2b_frame2: got seen=%0d tx=%h op=%h want seen=1 tx=00 op=22", ok, tx_data0, alu_op0);
        end
        pulse_tx_done();
        n_cmp++;
        if (starts0 - s !== 2 || busy0 !== 1'b0) begin
            n_bad++; $display("FAIL b2b_starts2: got starts=%0d busy=%b want 2 0", starts0 - s, busy0);
        end
    endtask

    task automatic test_overrun();
        bit ok;
        send0(8'h01); send0(8'h02); send0(8'h20);
        repeat (3) begin @(posedge clk); #1; end
        send0(8'h99);
        n_cmp++;
        if ({overrun0, busy0, tx_start0} !== 3'b110 || alu_a0 !== 8'h01) begin
            n_bad++; $display("FAIL ovr_set: got ovr=%b busy=%b st=%b a=%h want 1 1 0 01",
                              overrun0, busy0, tx_start0, alu_a0);
        end
        pulse_tx_done();
        n_cmp++;
        if ({busy0, overrun0} !== 2'b01) begin
            n_bad++; $display("FAIL ovr_sticky: got busy=%b ovr=%b want 0 1", busy0, overrun0);
        end
        send0(8'h04);
        n_cmp++;
        if (overrun0 !== 1'b0 || alu_a0 !== 8'h04) begin
            n_bad++; $display("FAIL ovr_clear: got ovr=%b a=%h want 0 04", overrun0, alu_a0);
        end
        send0(8'h05); send0(8'h20);
        wait_start0(ok);
        n_cmp++;
        if (!ok || tx_data0 !== 8'h09) begin
            n_bad++; $display("FAIL ovr_next_frame: got seen=%0d tx=%h want 1 09", ok, tx_data0);
        end
        pulse_tx_done();
    endtask

    task automatic test_timeout();
        bit ok;
        int hit;
        hit = 0;
        send1(8'h11);
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (timeout_tick1) begin hit = k; break; end
        end
        n_cmp++;
        if (hit != 50) begin n_bad++; $display("FAIL to_cycle: got %0d want 50", hit); end
        n_cmp++;
        if (busy1 !== 1'b0 || alu_a1 !== 8'h11) begin
            n_bad++; $display("FAIL to_idle: got busy=%b a=%h want 0 11", busy1, alu_a1);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (timeout_tick1 !== 1'b0) begin n_bad++; $display("FAIL to_pulse_width: got %b want 0", timeout_tick1); end
        send1(8'h02); send1(8'h02); send1(8'h20);
        wait_start1(ok);
        n_cmp++;
        if (!ok || tx_data1 !== 8'h04) begin
            n_bad++; $display("FAIL to_fresh_frame: got seen=%0d tx=%h want 1 04", ok, tx_data1);
        end
        pulse_tx_done();
        n_cmp++;
        if (busy1 !== 1'b0) begin n_bad++; $display("FAIL to_fresh_done: got %b want 0", busy1); end
    endtask

    task automatic test_coincident();
        bit ok;
        int seen;
        seen = 0;
        send1(8'h33);
        repeat (48) begin
            @(posedge clk); #1;
            if (timeout_tick1) seen++;
        end
        // B is sampled on the 50th edge after A, the expiry edge
        send1(8'h44);
        n_cmp++;
        if ({timeout_tick1, busy1} !== 2'b01 || alu_b1 !== 8'h44 || seen != 0) begin
            n_bad++; $display("FAIL coinc_accept: got to=%b busy=%b b=%h early_to=%0d want 0 1 44 0",
                              timeout_tick1, busy1, alu_b1, seen);
        end
        send1(8'h20);
        wait_start1(ok);
        n_cmp++;
        if (!ok || tx_data1 !== 8'h77) begin
            n_bad++; $display("FAIL coinc_result: got seen=%0d tx=%h want 1 77", ok, tx_data1);
        end
        pulse_tx_done();
    endtask

    task automatic test_reset_mid();
        bit ok;
        send0(8'h55); send0(8'h66);
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        n_cmp++;
        if ({alu_a0, alu_b0, alu_op0, tx_data0, tx_start0, busy0, overrun0, timeout_tick0} !== 38'h0) begin
            n_bad++; $display("FAIL rst_get_op: got a=%h b=%h busy=%b want all 0", alu_a0, alu_b0, busy0);
        end
        send0(8'h55); send0(8'h66); send0(8'h20);
        repeat (3) begin @(posedge clk); #1; end
        n_cmp++;
        if ({busy0, tx_start0, tx_data0} !== {1'b1, 1'b0, 8'hBB}) begin
            n_bad++; $display("FAIL rst_pre_wait: got busy=%b st=%b tx=%h want 1 0 bb", busy0, tx_start0, tx_data0);
        end
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        n_cmp++;
        if ({alu_a0, alu_b0, alu_op0, tx_data0, tx_start0, busy0, overrun0, timeout_tick0} !== 38'h0) begin
            n_bad++; $display("FAIL rst_wait_tx: got a=%h tx=%h busy=%b want all 0", alu_a0, tx_data0, busy0);
        end
        send0(8'h07); send0(8'h09); send0(8'h20);
        wait_start0(ok);
        n_cmp++;
        if (!ok || tx_data0 !== 8'h10) begin
            n_bad++; $display("FAIL rst_after_frame: got seen=%0d tx=%h want 1 10", ok, tx_data0);
        end
        pulse_tx_done();
        n_cmp++;
        if (busy0 !== 1'b0) begin n_bad++; $display("FAIL rst_after_done: got %b want 0", busy0); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overrun();
        test_timeout();
        test_coincident();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
